// File: rtl/aes_pkg.sv
// Shared AES datapath types and constants.
// Used by the S-box and by the serial SubBytes stage.
package aes_pkg;

  localparam int AES_NB_BYTES = 16;

  typedef logic [127:0] aes_state_t;
  typedef logic [7:0]   aes_byte_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } subbytes_state_e;

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box / inverse S-box.
// Uses the GF(2^8) inverse plus the affine map rather than a stored table.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] U,
  input  logic       dec,
  output logic [7:0] S
);

  function automatic aes_byte_t gf_mul(input aes_byte_t a, input aes_byte_t b);
    aes_byte_t p;
    aes_byte_t aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 for nonzero a, and maps 0 to 0 as AES requires.
  function automatic aes_byte_t gf_inv(input aes_byte_t a);
    aes_byte_t t;
    aes_byte_t r;
    t = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      t = gf_mul(t, t);
      r = gf_mul(r, t);
    end
    return r;
  endfunction

  function automatic aes_byte_t rotl(input aes_byte_t x, input int n);
    aes_byte_t r;
    r = x;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic aes_byte_t affine_fwd(input aes_byte_t x);
    return x ^ rotl(x, 1) ^ rotl(x, 2) ^ rotl(x, 3) ^ rotl(x, 4) ^ 8'h63;
  endfunction

  function automatic aes_byte_t affine_inv(input aes_byte_t x);
    return rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
  endfunction

  always_comb begin
    if (dec) S = gf_inv(affine_inv(U));
    else     S = affine_fwd(gf_inv(U));
  end

endmodule

// File: rtl/aes_subbytes_serial.sv
// Serial SubBytes/InvSubBytes: LANES S-boxes walk the 16 state bytes in
// 16/LANES cycles, with valid/ready on both sides and one block in flight.
module aes_subbytes_serial
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_dec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  localparam int GROUPS = AES_NB_BYTES / LANES;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  subbytes_state_e r_fsm;
  aes_state_t      r_st;
  logic            r_dec;
  logic [GW-1:0]   r_grp;
  logic            r_in_ready;
  logic            r_out_valid;

  aes_byte_t       w_lane_in  [LANES];
  aes_byte_t       w_lane_out [LANES];
  aes_state_t      w_next_st;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    always_comb begin
      w_lane_in[gi] = r_st[127 - 8 * (int'(r_grp) * LANES + gi) -: 8];
    end

    aes_sbox u_sbox (
      .U   (w_lane_in[gi]),
      .dec (r_dec),
      .S   (w_lane_out[gi])
    );
  end

  // Only the bytes of the current group are replaced; the rest are held.
  always_comb begin
    w_next_st = r_st;
    for (int j = 0; j < LANES; j++) begin
      w_next_st[127 - 8 * (int'(r_grp) * LANES + j) -: 8] = w_lane_out[j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= IDLE;
      r_st        <= '0;
      r_dec       <= 1'b0;
      r_grp       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_st       <= in_state;
            r_dec      <= in_dec;
            r_grp      <= '0;
            r_fsm      <= BUSY;
            r_in_ready <= 1'b0;
          end
        end
        BUSY: begin
          r_st <= w_next_st;
          if (r_grp == GW'(GROUPS - 1)) begin
            r_fsm       <= DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_grp <= r_grp + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_fsm       <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_fsm       <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_state = r_st;

endmodule
